// File: rtl/matmul_bram_sequencer_if.sv
// Bus bundle between the BRAM read sequencer and its environment.
// Carries the control inputs, the two BRAM port-B read buses, tile
// progress and status. When MATMUL_SEQ_PERF_EN is defined the bundle
// also carries the perf_cycles and stall_cycles counters.
interface matmul_bram_sequencer_if #(
    parameter int ROW_TILES    = 2,
    parameter int COL_TILES    = 2,
    parameter int ADDR_WIDTH_A = 8,
    parameter int ADDR_WIDTH_B = 8
);
    logic                             start;
    logic                             stall;
    logic                             core_done;
    logic                             in_rd_en;
    logic [ADDR_WIDTH_A-1:0]          in_rd_addr;
    logic                             w_rd_en;
    logic [ADDR_WIDTH_B-1:0]          w_rd_addr;
    logic                             rd_valid;
    logic                             en_module;
    logic [$clog2(ROW_TILES):0]       tile_row;
    logic [$clog2(COL_TILES):0]       tile_col;
    logic                             tile_done;
    logic                             busy;
    logic                             done;
    logic                             err;
`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0]                      perf_cycles;
    logic [31:0]                      stall_cycles;
`endif

    modport master (
        input  start, stall, core_done,
`ifdef MATMUL_SEQ_PERF_EN
        output perf_cycles, stall_cycles,
`endif
        output in_rd_en, in_rd_addr, w_rd_en, w_rd_addr, rd_valid,
        output en_module, tile_row, tile_col, tile_done, busy, done, err
    );

    modport slave (
        output start, stall, core_done,
`ifdef MATMUL_SEQ_PERF_EN
        input  perf_cycles, stall_cycles,
`endif
        input  in_rd_en, in_rd_addr, w_rd_en, w_rd_addr, rd_valid,
        input  en_module, tile_row, tile_col, tile_done, busy, done, err
    );
endinterface

// File: rtl/matmul_bram_sequencer.sv
// Read-side sequencer for the input-matrix and weight BRAMs feeding
// multi_matmul_wrapper. Walks the output tiles of C (row tiles outer,
// column tiles inner), streams INNER_STEPS read addresses per tile to both
// BRAMs, then waits for the core's per-tile done before moving on.
// Optional feature macro: MATMUL_SEQ_PERF_EN adds perf_cycles/stall_cycles.
module matmul_bram_sequencer #(
    parameter int ROW_TILES    = 2,
    parameter int COL_TILES    = 2,
    parameter int INNER_STEPS  = 4,
    parameter int ADDR_WIDTH_A = 8,
    parameter int ADDR_WIDTH_B = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    matmul_bram_sequencer_if.master  bus
);
    localparam int RW = $clog2(ROW_TILES) + 1;
    localparam int CW = $clog2(COL_TILES) + 1;
    localparam int KW = $clog2(INNER_STEPS) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, NEXT} state_t;

    state_t                  state, state_nxt;
    logic [RW-1:0]           row;
    logic [CW-1:0]           col;
    logic [KW-1:0]           k;
    logic [ADDR_WIDTH_A-1:0] in_addr_q;
    logic [ADDR_WIDTH_B-1:0] w_addr_q;
    logic [ADDR_WIDTH_A-1:0] in_addr_nxt;
    logic [ADDR_WIDTH_B-1:0] w_addr_nxt;
    logic [READ_LATENCY-1:0] vld_p;
    logic                    issue;
    logic                    done_q;
    logic                    err_q;
    logic                    last_k, last_col, last_row;

    assign last_k   = (k   == KW'(INNER_STEPS - 1));
    assign last_col = (col == CW'(COL_TILES - 1));
    assign last_row = (row == RW'(ROW_TILES - 1));

    // Full-width address arithmetic, truncated to the BRAM port width.
    assign in_addr_nxt = ADDR_WIDTH_A'(32'(row) * 32'(INNER_STEPS) + 32'(k));
    assign w_addr_nxt  = ADDR_WIDTH_B'(32'(col) * 32'(INNER_STEPS) + 32'(k));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; an issue happens in every unstalled ISSUE cycle.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = ISSUE;
            ISSUE: begin
                if (!bus.stall) begin
                    issue = 1'b1;
                    if (last_k) state_nxt = WAIT;
                end
            end
            WAIT:  if (bus.core_done) state_nxt = NEXT;
            NEXT:  state_nxt = (last_col && last_row) ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tile/step counters, held addresses, done pulse and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            row       <= '0;
            col       <= '0;
            k         <= '0;
            in_addr_q <= '0;
            w_addr_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= (state == NEXT) && last_col && last_row;
            if (bus.core_done && state != WAIT) err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        row <= '0;
                        col <= '0;
                        k   <= '0;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        in_addr_q <= in_addr_nxt;
                        w_addr_q  <= w_addr_nxt;
                        k         <= k + KW'(1);
                    end
                end
                NEXT: begin
                    k <= '0;
                    if (!last_col) begin
                        col <= col + CW'(1);
                    end else if (!last_row) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read-valid pipeline: in_rd_en delayed by READ_LATENCY cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

`ifdef MATMUL_SEQ_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] stall_cnt;

    // Run counters; the start-accepting cycle counts as the run's first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt  <= '0;
            stall_cnt <= '0;
        end else if (state == IDLE && bus.start) begin
            perf_cnt  <= 32'd1;
            stall_cnt <= '0;
        end else begin
            if (state != IDLE && perf_cnt != '1) perf_cnt <= perf_cnt + 32'd1;
            if (state == ISSUE && bus.stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.perf_cycles  = perf_cnt;
    assign bus.stall_cycles = stall_cnt;
`endif

    assign bus.in_rd_en   = issue;
    assign bus.w_rd_en    = issue;
    assign bus.in_rd_addr = issue ? in_addr_nxt : in_addr_q;
    assign bus.w_rd_addr  = issue ? w_addr_nxt  : w_addr_q;
    assign bus.rd_valid   = vld_p[READ_LATENCY-1];
    assign bus.en_module  = (state != IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.tile_row   = row;
    assign bus.tile_col   = col;
    assign bus.tile_done  = (state == NEXT);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule
